// File: rtl/l2_sched_pkg.sv
// Shared types for the L2 request scheduler: request kinds, FSM states and
// the holding-register payload.
package l2_sched_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LINE_W  = 256;
  localparam int unsigned NUM_REQ = 3;

  typedef enum logic [1:0] {
    DC_WR = 2'd0,
    DC_RD = 2'd1,
    IC_RD = 2'd2
  } req_kind_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    req_kind_t           kind;
    logic [ADDR_W-1:0]   addr;
    logic [LINE_W-1:0]   data;
  } hold_entry_t;

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter; search starts one past the last grant.
module rr_arbiter3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] grant,
  output logic [1:0] grant_idx
);

  logic [1:0] start;
  logic [2:0] sum;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    // An out-of-range pointer behaves like the last index so start wraps to 0.
    start     = (last >= 2'd2) ? 2'd0 : 2'(last + 2'd1);
    for (int k = 0; k < 3; k++) begin
      sum = 3'({1'b0, start}) + 3'(k);
      idx = 2'((sum >= 3'd3) ? (sum - 3'd3) : sum);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/l2_request_scheduler.sv
// Single-outstanding scheduler between icache/dcache requesters and memory:
// round-robin accept, hold-and-issue, response routing and read timeout.
module l2_request_scheduler
  import l2_sched_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS   = ADDR_W,
  parameter int unsigned BLOCK_DW       = LINE_W,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ic_rd_valid,
  output logic                    ic_rd_ready,
  input  logic [ADDRESS_BITS-1:0] ic_rd_addr,
  input  logic                    dc_rd_valid,
  output logic                    dc_rd_ready,
  input  logic [ADDRESS_BITS-1:0] dc_rd_addr,
  input  logic                    dc_wr_valid,
  output logic                    dc_wr_ready,
  input  logic [ADDRESS_BITS-1:0] dc_wr_addr,
  input  logic [BLOCK_DW-1:0]     dc_wr_data,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [1:0]              mem_req_kind,
  output logic [ADDRESS_BITS-1:0] mem_req_addr,
  output logic [BLOCK_DW-1:0]     mem_req_data,
  input  logic                    mem_rsp_valid,
  input  logic [BLOCK_DW-1:0]     mem_rsp_data,
  output logic                    ic_rsp_valid,
  output logic [BLOCK_DW-1:0]     ic_rsp_data,
  output logic                    dc_rsp_valid,
  output logic [ADDRESS_BITS-1:0] dc_rsp_addr,
  output logic [BLOCK_DW-1:0]     dc_rsp_data,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state_q, state_d;
  hold_entry_t        hold_q, hold_d;
  logic [1:0]         last_q;
  logic [CNT_W-1:0]   tmo_cnt_q;
  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         grant_idx;
  logic               accept;
  logic               rsp_fire;
  logic               timeout_hit;

  assign req_vec = {ic_rd_valid, dc_rd_valid, dc_wr_valid};

  rr_arbiter3 u_arb (
    .req       (req_vec),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Readies are forced low during reset so nothing is accepted while held.
  assign dc_wr_ready = rst_n & (state_q == IDLE) & grant[0];
  assign dc_rd_ready = rst_n & (state_q == IDLE) & grant[1];
  assign ic_rd_ready = rst_n & (state_q == IDLE) & grant[2];

  assign mem_req_valid = (state_q == ISSUE);
  assign mem_req_kind  = hold_q.kind;
  assign mem_req_addr  = ADDRESS_BITS'(hold_q.addr);
  assign mem_req_data  = BLOCK_DW'(hold_q.data);
  assign busy          = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    rsp_fire    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_vec) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) state_d = (hold_q.kind == DC_WR) ? IDLE : WAIT;
      end
      WAIT: begin
        // A response arriving on the last allowed cycle still wins over abort.
        if (mem_rsp_valid) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture of the winning requester; reads carry no data.
  always_comb begin
    hold_d      = '0;
    hold_d.kind = req_kind_t'(grant_idx);
    case (grant_idx)
      2'd0: begin
        hold_d.addr = ADDR_W'(dc_wr_addr);
        hold_d.data = LINE_W'(dc_wr_data);
      end
      2'd1:    hold_d.addr = ADDR_W'(dc_rd_addr);
      default: hold_d.addr = ADDR_W'(ic_rd_addr);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q       <= '0;
      last_q       <= 2'd2;
      tmo_cnt_q    <= '0;
      timeout_err  <= 1'b0;
      ic_rsp_valid <= 1'b0;
      ic_rsp_data  <= '0;
      dc_rsp_valid <= 1'b0;
      dc_rsp_addr  <= '0;
      dc_rsp_data  <= '0;
    end else begin
      ic_rsp_valid <= rsp_fire && (hold_q.kind == IC_RD);
      dc_rsp_valid <= rsp_fire && (hold_q.kind != IC_RD);
      if (accept) begin
        hold_q <= hold_d;
        last_q <= grant_idx;
      end
      if (state_q == ISSUE)     tmo_cnt_q <= '0;
      else if (state_q == WAIT) tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      if (timeout_hit) timeout_err <= 1'b1;
      if (rsp_fire) begin
        if (hold_q.kind == IC_RD) begin
          ic_rsp_data <= mem_rsp_data;
        end else begin
          dc_rsp_data <= mem_rsp_data;
          dc_rsp_addr <= ADDRESS_BITS'(hold_q.addr);
        end
      end
    end
  end

endmodule
